// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: owns the PC, drives imem through req/ack and hands
// fetched words to decode over valid/ready, honouring redirects even mid-access.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
`ifndef IMEM_DATA_WIDTH
`define IMEM_DATA_WIDTH 32
`endif

module fetch_controller #(
  parameter logic [`IMEM_ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        redirect_valid,
  input  logic [`IMEM_ADDR_WIDTH-1:0] redirect_pc,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [`IMEM_DATA_WIDTH-1:0] instr,
  output logic [`IMEM_ADDR_WIDTH-1:0] instr_pc,
  output logic [`IMEM_ADDR_WIDTH-1:0] pc,
  output logic                        mem_req,
  output logic [`IMEM_ADDR_WIDTH-1:0] mem_addr,
  input  logic                        mem_ack,
  input  logic [`IMEM_DATA_WIDTH-1:0] mem_value
);

  typedef enum logic [1:0] {StIdle, StFetch, StValid, StDiscard} state_e;

  state_e                      state_q, state_d;
  logic [`IMEM_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [`IMEM_ADDR_WIDTH-1:0] pending_q, pending_d;
  logic [`IMEM_ADDR_WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic [`IMEM_DATA_WIDTH-1:0] instr_q, instr_d;
  state_e                      next_run;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    next_run   = enable ? StFetch : StIdle;
    unique case (state_q)
      StIdle: begin
        if (redirect_valid) pc_d = redirect_pc;
        if (enable) state_d = StFetch;
      end
      StFetch: begin
        if (mem_ack) begin
          if (redirect_valid) begin
            pc_d    = redirect_pc;
            state_d = next_run;
          end else begin
            instr_d    = mem_value;
            instr_pc_d = pc_q;
            pc_d       = pc_q + 1'b1;
            state_d    = StValid;
          end
        end else if (redirect_valid) begin
          // pc keeps the abandoned address so mem_addr stays stable until ack
          pending_d = redirect_pc;
          state_d   = StDiscard;
        end
      end
      StValid: begin
        if (redirect_valid) begin
          pc_d    = redirect_pc;
          state_d = next_run;
        end else if (instr_ready) begin
          state_d = next_run;
        end
      end
      StDiscard: begin
        if (redirect_valid) pending_d = redirect_pc;
        if (mem_ack) begin
          pc_d    = redirect_valid ? redirect_pc : pending_q;
          state_d = next_run;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      pc_q       <= RESET_PC;
      pending_q  <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign mem_req     = (state_q == StFetch) || (state_q == StDiscard);
  assign instr_valid = (state_q == StValid);
  assign mem_addr    = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_controller.sv
// Directed vector bench for fetch_controller: 8-bit addresses, RESET_PC = 0x10.
`ifndef IMEM_ADDR_WIDTH
`define IMEM_ADDR_WIDTH 8
`endif
`ifndef IMEM_DATA_WIDTH
`define IMEM_DATA_WIDTH 32
`endif

module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [7:0]  redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [7:0]  instr_pc;
  logic [7:0]  pc;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_value = '0;

  int checks = 0;
  int errors = 0;

  fetch_controller #(.RESET_PC(8'h10)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc             (pc),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_value      (mem_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst_n, en, rv;
    logic [7:0]  rpc;
    bit          rdy, ack;
    logic [31:0] val;
    bit          ereq;
    logic [7:0]  eaddr;
    bit          eiv;
    logic [7:0]  eipc;
    logic [31:0] einstr;
    logic [7:0]  epc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst_n, en, rv, input logic [7:0] rpc, input bit rdy, ack,
                     input logic [31:0] val, input bit ereq, input logic [7:0] eaddr,
                     input bit eiv, input logic [7:0] eipc, input logic [31:0] einstr,
                     input logic [7:0] epc);
    vec_t v;
    v = '{rst_n, en, rv, rpc, rdy, ack, val, ereq, eaddr, eiv, eipc, einstr, epc};
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got 0x%0h expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input bit rst_n, en, rv, input logic [7:0] rpc, input bit rdy, ack,
                       input logic [31:0] val);
    @(negedge clk);
    reset_n = rst_n; enable = en; redirect_valid = rv; redirect_pc = rpc;
    instr_ready = rdy; mem_ack = ack; mem_value = val;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //  rst en rv rpc    rdy ack val             req addr   iv ipc    instr         pc
    add(0, 0, 0, 8'h00, 0, 0, 32'h0,           0, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 1, 1, 32'hB5,          0, 8'h11, 1, 8'h10, 32'hB5,    8'h11);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h11, 0, 8'h00, 32'h0,     8'h11);
    add(1, 1, 0, 8'h00, 1, 1, 32'hB4,          0, 8'h12, 1, 8'h11, 32'hB4,    8'h12);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h12, 0, 8'h00, 32'h0,     8'h12);
    for (int i = 0; i < 3; i++)
      add(1, 1, 0, 8'h00, 0, 0, 32'h0,         1, 8'h12, 0, 8'h00, 32'h0,     8'h12);
    add(1, 1, 0, 8'h00, 0, 1, 32'hB7,          0, 8'h13, 1, 8'h12, 32'hB7,    8'h13);
    for (int i = 0; i < 4; i++)  // held under backpressure; stray ack ignored
      add(1, 1, 0, 8'h00, 0, bit'(i == 1), 32'hFFFF, 0, 8'h13, 1, 8'h12, 32'hB7, 8'h13);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h13, 0, 8'h00, 32'h0,     8'h13);
    add(1, 1, 1, 8'h05, 1, 1, 32'hDEAD,        1, 8'h05, 0, 8'h00, 32'h0,     8'h05);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h05, 0, 8'h00, 32'h0,     8'h05);
    add(1, 1, 1, 8'h40, 1, 0, 32'h0,           1, 8'h05, 0, 8'h00, 32'h0,     8'h05);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h05, 0, 8'h00, 32'h0,     8'h05);
    add(1, 1, 0, 8'h00, 1, 1, 32'hA0,          1, 8'h40, 0, 8'h00, 32'h0,     8'h40);
    add(1, 1, 1, 8'h20, 1, 0, 32'h0,           1, 8'h40, 0, 8'h00, 32'h0,     8'h40);
    add(1, 1, 1, 8'h40, 1, 0, 32'h0,           1, 8'h40, 0, 8'h00, 32'h0,     8'h40);
    add(1, 1, 1, 8'h80, 1, 0, 32'h0,           1, 8'h40, 0, 8'h00, 32'h0,     8'h40);
    add(1, 1, 0, 8'h00, 1, 1, 32'h1234,        1, 8'h80, 0, 8'h00, 32'h0,     8'h80);
    add(1, 1, 1, 8'hFF, 1, 1, 32'h5555,        1, 8'hFF, 0, 8'h00, 32'h0,     8'hFF);
    add(1, 1, 0, 8'h00, 1, 1, 32'h5A,          0, 8'h00, 1, 8'hFF, 32'h5A,    8'h00);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h00, 0, 8'h00, 32'h0,     8'h00);
    add(1, 0, 0, 8'h00, 1, 0, 32'h0,           1, 8'h00, 0, 8'h00, 32'h0,     8'h00);
    add(1, 0, 0, 8'h00, 1, 1, 32'hA5,          0, 8'h01, 1, 8'h00, 32'hA5,    8'h01);
    add(1, 0, 0, 8'h00, 1, 0, 32'h0,           0, 8'h01, 0, 8'h00, 32'h0,     8'h01);
    add(1, 0, 0, 8'h00, 1, 1, 32'hBAD,         0, 8'h01, 0, 8'h00, 32'h0,     8'h01);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h01, 0, 8'h00, 32'h0,     8'h01);
    add(0, 1, 0, 8'h00, 1, 0, 32'h0,           0, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 1, 0, 32'h0,           1, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 0, 1, 32'hB5,          0, 8'h11, 1, 8'h10, 32'hB5,    8'h11);
    add(0, 1, 0, 8'h00, 0, 0, 32'h0,           0, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 0, 0, 32'h0,           1, 8'h10, 0, 8'h00, 32'h0,     8'h10);
    add(1, 1, 0, 8'h00, 0, 1, 32'hB5,          0, 8'h11, 1, 8'h10, 32'hB5,    8'h11);
    add(1, 1, 1, 8'h30, 0, 0, 32'h0,           1, 8'h30, 0, 8'h00, 32'h0,     8'h30);
    add(1, 1, 0, 8'h00, 0, 1, 32'h95,          0, 8'h31, 1, 8'h30, 32'h95,    8'h31);
    add(1, 0, 1, 8'h50, 1, 0, 32'h0,           0, 8'h50, 0, 8'h00, 32'h0,     8'h50);
    add(1, 1, 1, 8'h60, 1, 0, 32'h0,           1, 8'h60, 0, 8'h00, 32'h0,     8'h60);
    add(1, 1, 1, 8'h70, 1, 0, 32'h0,           1, 8'h60, 0, 8'h00, 32'h0,     8'h60);
    add(1, 1, 1, 8'h77, 1, 1, 32'h99,          1, 8'h77, 0, 8'h00, 32'h0,     8'h77);

    foreach (vecs[i]) begin
      drive(vecs[i].rst_n, vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].rdy, vecs[i].ack,
            vecs[i].val);
      chk("mem_req", i, 32'(mem_req), 32'(vecs[i].ereq));
      chk("instr_valid", i, 32'(instr_valid), 32'(vecs[i].eiv));
      chk("pc", i, 32'(pc), 32'(vecs[i].epc));
      if (vecs[i].ereq) chk("mem_addr", i, 32'(mem_addr), 32'(vecs[i].eaddr));
      // Payload only defined while valid, or zeroed by reset
      if (vecs[i].eiv || !vecs[i].rst_n) begin
        chk("instr_pc", i, 32'(instr_pc), 32'(vecs[i].eipc));
        chk("instr", i, instr, vecs[i].einstr);
      end
    end

    // Reset while waiting in DISCARD abandons the access
    drive(1, 1, 1, 8'h22, 1, 0, 32'h0);
    chk("discard_req", 100, 32'(mem_req), 32'd1);
    chk("discard_addr", 100, 32'(mem_addr), 32'h77);
    drive(0, 1, 0, 8'h00, 1, 0, 32'h0);
    chk("rst_req", 101, 32'(mem_req), 32'd0);
    chk("rst_valid", 101, 32'(instr_valid), 32'd0);
    chk("rst_pc", 101, 32'(pc), 32'h10);
    drive(1, 1, 0, 8'h00, 1, 0, 32'h0);
    chk("restart_addr", 102, 32'(mem_addr), 32'h10);
    chk("restart_req", 102, 32'(mem_req), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
